instruction_encoder: RTL
========================

# instruction_encoder

Assembles RV32I instruction words from decoded fields (opcode, func3, func7, rd, rs1, rs2, immediate) and emits them with a byte address. It is the inverse of the instruction decoder: fields in, 32-bit instruction word out. It sits in front of instruction memory as the program-loader/self-test stimulus source. It is a single-stage registered pipeline with valid/ready handshakes on both sides and an auto-incrementing address counter.

## Interface
- `ADDR_W`, default 10: width of the byte-address counter.
- `BASE_ADDR`, default 0: first address emitted after reset or flush. Must be a multiple of 4.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; drops the held word and reloads the address counter.
- `in_valid`  in  1  field set is valid.
- `in_ready`  out  1  encoder can accept a field set this cycle.
- `opcode`  in  7  RV32I opcode.
- `func3`  in  3  funct3.
- `func7`  in  7  funct7 (R-type only).
- `rd`, `rs1`, `rs2`  in  5 each  register indices.
- `imm`  in  32  sign-extended immediate. For U-type, the value with bits [11:0] = 0.
- `out_valid`  out  1  `instruction`/`pc_addr` valid.
- `out_ready`  in  1  consumer accepts the output this cycle.
- `instruction`  out  32  encoded word.
- `pc_addr`  out  ADDR_W  byte address of `instruction`.
- `illegal`  out  1  one-cycle pulse: unsupported opcode dropped (see Configuration).

## Operation
Field placement by opcode:
- R (0110011): func7, rs2, rs1, func3, rd, op.
- I (0010011, 0000011, 1100111): imm[11:0], rs1, func3, rd, op.
- S (0100011): imm[11:5], rs2, rs1, func3, imm[4:0], op.
- B (1100011): imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], op.
- U (0110111, 0010111): imm[31:12], rd, op.
- J (1101111): imm[20], imm[10:1], imm[11], imm[19:12], rd, op.

General rules:
- Unused input fields are ignored. `imm` bits above the format's range are ignored; no range check is performed.
- Accept condition: `in_valid && in_ready`, where `in_ready = !out_valid || out_ready` (combinational; pass-through at full rate).
- On accept of a legal opcode:
  - `instruction` <= encoded word.
  - `pc_addr` <= `next_addr`.
  - `out_valid` <= 1.
  - `next_addr` <= `next_addr + 4`, modulo 2^ADDR_W (wraps to 0, not to BASE_ADDR).
- If `out_valid && out_ready` with no accept: `out_valid` <= 0. `instruction` and `pc_addr` hold their last values.
- While `out_valid && !out_ready`: `instruction` and `pc_addr` hold stable and `in_ready` = 0.
- `flush`: `out_valid` <= 0 and `next_addr` <= BASE_ADDR. It takes priority over a simultaneous accept or output handshake; the offered input is not consumed, and `in_ready` is forced to 0 during `flush`.

## Timing
- Latency: 1 cycle from accept to `out_valid`. Throughput: 1 word/cycle when `out_ready` is held high.
- Reset (asynchronous, any time, including mid-transfer):
  - `out_valid` = 0, `instruction` = 0, `pc_addr` = 0, `illegal` = 0.
  - `next_addr` = BASE_ADDR.
  - `in_ready` = 1 in the first cycle after reset release.
- `illegal` is registered: it asserts the cycle after the offending accept, for exactly 1 cycle.

## Configuration
- `ENCODER_ILLEGAL_CHECK_EN` defined:
  - An accept with an opcode outside the list above is consumed, but no output is produced.
  - `out_valid` <= 0 if the previous word was handed off that cycle; otherwise the held word is unchanged.
  - `next_addr` is unchanged and `illegal` pulses.
- Undefined: unknown opcodes are encoded with the R-type layout, and `illegal` is tied to 0.

## Test plan
- add x3,x1,x2 (func7=0, rs2=2, rs1=1, f3=0, rd=3, op=0x33) -> `instruction` = 0x002081B3, `pc_addr` = 0. With func7=0x20, the next word is 0x402081B3 at `pc_addr` = 4.
- lbu (imm=4, rs1=1, f3=4, rd=3, op=0x03) -> 0x0040C183. lui x2, imm=0x00001000 -> 0x00001137.
- beq x1,x2,-4 (imm=0xFFFFFFFC) -> 0xFE208EE3.
- `out_ready` = 0 for 3 cycles with `in_valid` high -> `in_ready` = 0, output held stable, no word lost or duplicated. After release, back-to-back words appear at consecutive addresses.
- ADDR_W=4: five accepts -> `pc_addr` sequence 0, 4, 8, 12, 0. Then `flush` together with `in_valid` -> that input is not consumed and the next word is emitted at `pc_addr` = 0.
- With macro: opcode 0x7F -> no `out_valid`, `illegal` high for 1 cycle, next legal word takes the unchanged address. Without macro: 0x7F is encoded in R-type layout. `rst` pulsed mid-backpressure -> all outputs 0 immediately.

Source files
------------

// File: rtl/instruction_encoder.sv
// RV32I field-to-word encoder: one registered output stage with valid/ready on both sides and
// an auto-incrementing byte address. Define ENCODER_ILLEGAL_CHECK_EN to drop unknown opcodes.
module instruction_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              illegal
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(4);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [2:0] {
        FmtR,
        FmtI,
        FmtS,
        FmtB,
        FmtU,
        FmtJ,
        FmtUnknown
    } fmt_e;

    fmt_e              fmt;
    logic [31:0]       enc_word;
    logic              legal;
    logic              accept;
    logic              out_fire;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;

    always_comb begin
        case (opcode)
            OpReg:                   fmt = FmtR;
            OpImm, OpLoad, OpJalr:   fmt = FmtI;
            OpStore:                 fmt = FmtS;
            OpBranch:                fmt = FmtB;
            OpLui, OpAuipc:          fmt = FmtU;
            OpJal:                   fmt = FmtJ;
            default:                 fmt = FmtUnknown;
        endcase
    end

    // Unknown opcodes fall through to the R-type layout when not rejected.
    always_comb begin
        case (fmt)
            FmtI:    enc_word = {imm[11:0], rs1, func3, rd, opcode};
            FmtS:    enc_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            FmtB:    enc_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
            FmtU:    enc_word = {imm[31:12], rd, opcode};
            FmtJ:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: enc_word = {func7, rs2, rs1, func3, rd, opcode};
        endcase
    end

`ifdef ENCODER_ILLEGAL_CHECK_EN
    assign legal = (fmt != FmtUnknown);
`else
    assign legal = 1'b1;
`endif

    // Flush blocks acceptance so the offered field set stays with the producer.
    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        next_addr_d = next_addr_q;
        if (flush) begin
            out_valid_d = 1'b0;
            next_addr_d = BaseAddr;
        end else begin
            if (out_fire) begin
                out_valid_d = 1'b0;
            end
            if (accept && legal) begin
                out_valid_d = 1'b1;
                instr_d     = enc_word;
                pc_d        = next_addr_q;
                next_addr_d = next_addr_q + AddrStep;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            next_addr_q <= BaseAddr;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            next_addr_q <= next_addr_d;
        end
    end

`ifdef ENCODER_ILLEGAL_CHECK_EN
    logic illegal_q, illegal_d;

    assign illegal_d = accept && !legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign out_valid   = out_valid_q;
    assign instruction = instr_q;
    assign pc_addr     = pc_q;

endmodule
